// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic widths and divider FSM state encodings
package arith_pkg;

    localparam int DW_DEF = 8;
    localparam int VW_DEF = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step
    import arith_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   rem_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   rem_out,
    output logic          q_bit
);

    logic [VW+1:0] shifted;

    // Shift the next dividend bit in, subtract the divisor only when it fits.
    always_comb begin
        shifted = {rem_in, bit_in};
        rem_out = shifted[VW:0];
        q_bit   = 1'b0;
        if (shifted >= {2'b00, divisor}) begin
            rem_out = (VW+1)'(shifted - {2'b00, divisor});
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider (optional DIVIDER_DIVZERO_CHK_EN)
module restoring_divider
    import arith_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done
`ifdef DIVIDER_DIVZERO_CHK_EN
    ,
    output logic          div_by_zero
`endif
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [DW-1:0] q_sh;
    logic [VW-1:0] dvs;
    logic [VW-1:0] dvd_lo;
    logic [VW:0]   part_rem;
    logic          dz;
    logic          skip_calc;
    logic [VW:0]   step_rem;
    logic          step_q;

    // Zero divisor short-circuits the iteration only when the check is built in.
`ifdef DIVIDER_DIVZERO_CHK_EN
    assign skip_calc = dz;
`else
    assign skip_calc = 1'b0;
`endif

    div_step #(.VW(VW)) u_step (
        .rem_in  (part_rem),
        .bit_in  (q_sh[DW-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Status flags decode straight from the state register, so busy and done never overlap.
    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // FSM, iteration registers and result registers; the dividend register
    // shifts left and fills with quotient bits, ending up holding the quotient.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            count       <= '0;
            q_sh        <= '0;
            dvs         <= '0;
            dvd_lo      <= '0;
            part_rem    <= '0;
            dz          <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIVIDER_DIVZERO_CHK_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= CALC;
                        count    <= '0;
                        q_sh     <= dividend;
                        dvs      <= divisor;
                        dvd_lo   <= dividend[VW-1:0];
                        part_rem <= '0;
                        dz       <= (divisor == '0);
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (skip_calc) begin
                        state       <= DONE;
                        quotient    <= '1;
                        remainder   <= dvd_lo;
`ifdef DIVIDER_DIVZERO_CHK_EN
                        div_by_zero <= 1'b1;
`endif
                    end else begin
                        q_sh     <= {q_sh[DW-2:0], step_q};
                        part_rem <= step_rem;
                        count    <= count + 1'b1;
                        if (count == CW'(DW-1)) begin
                            state     <= DONE;
                            quotient  <= dz ? '1 : {q_sh[DW-2:0], step_q};
                            remainder <= dz ? dvd_lo : step_rem[VW-1:0];
`ifdef DIVIDER_DIVZERO_CHK_EN
                            div_by_zero <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - self-checking bench for restoring_divider (honours DIVIDER_DIVZERO_CHK_EN)
module tb_restoring_divider;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
`ifdef DIVIDER_DIVZERO_CHK_EN
    logic       div_by_zero;
    localparam int DZ_LAT = 1;
`else
    localparam int DZ_LAT = 8;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
    } vec_t;

    vec_t vecs[10];

    restoring_divider dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done)
`ifdef DIVIDER_DIVZERO_CHK_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts rising edges until done is seen on a falling edge; -1 if never.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && busy) overlap++;
            if (done) begin
                lat = i;
                return;
            end
        end
    endtask

    // Pulses start for one cycle, then scrambles the operands to prove they were latched.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        vecs[0] = '{8'd45,  4'd9,  8'd5,   4'd0};
        vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0};
        vecs[2] = '{8'd255, 4'd15, 8'd17,  4'd0};
        vecs[3] = '{8'd9,   4'd10, 8'd0,   4'd9};
        vecs[4] = '{8'd100, 4'd7,  8'd14,  4'd2};
        vecs[5] = '{8'd200, 4'd3,  8'd66,  4'd2};
        vecs[6] = '{8'hA5,  4'd0,  8'hFF,  4'h5};
        vecs[7] = '{8'd0,   4'd5,  8'd0,   4'd0};
        vecs[8] = '{8'd200, 4'd13, 8'd15,  4'd5};
        vecs[9] = '{8'd17,  4'd4,  8'd4,   4'd1};

        n_rst    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_quotient",  quotient,  0);
        chk("reset_remainder", remainder, 0);
        chk("reset_busy",      busy,      0);
        chk("reset_done",      done,      0);
`ifdef DIVIDER_DIVZERO_CHK_EN
        chk("reset_dz", div_by_zero, 0);
`endif
        n_rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].dvd, vecs[i].dvs);
            chk($sformatf("v%0d_busy_after_start", i), busy, 1);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, (vecs[i].dvs == 0) ? DZ_LAT : 8);
            chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
`ifdef DIVIDER_DIVZERO_CHK_EN
            chk($sformatf("v%0d_div_by_zero", i), div_by_zero, (vecs[i].dvs == 0) ? 1 : 0);
`endif
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", i), done, 0);
            chk($sformatf("v%0d_hold_quotient", i), quotient, vecs[i].q);
        end

        // Back-to-back: second start issued during the first done cycle.
        launch(8'd100, 4'd7);
        wait_done(lat);
        chk("b2b_first_latency", lat, 8);
        chk("b2b_first_q", quotient, 14);
        chk("b2b_first_r", remainder, 2);
        dividend = 8'd200;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy_gap", busy, 1);
        wait_done(lat);
        chk("b2b_second_latency", lat, 8);
        chk("b2b_second_q", quotient, 66);
        chk("b2b_second_r", remainder, 2);

        // Start while busy with different operands must be ignored.
        launch(8'd45, 4'd9);
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ignored_start_latency", lat, 5);
        chk("ignored_start_q", quotient, 5);
        chk("ignored_start_r", remainder, 0);
        count_done(12, seen);
        chk("ignored_start_single_done", seen, 0);

        // Asynchronous reset in the middle of a calculation.
        launch(8'd200, 4'd13);
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midreset_quotient",  quotient,  0);
        chk("midreset_remainder", remainder, 0);
        chk("midreset_busy",      busy,      0);
        chk("midreset_done",      done,      0);
        @(negedge clk);
        n_rst = 1'b1;
        count_done(12, seen);
        chk("midreset_no_done", seen, 0);
        launch(8'd200, 4'd13);
        wait_done(lat);
        chk("post_reset_latency", lat, 8);
        chk("post_reset_q", quotient, 15);
        chk("post_reset_r", remainder, 5);

        chk("busy_done_exclusive", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
